// File: rtl/masked_subbytes_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : masked_subbytes_ctrl_if
// Brief    : Start/state/S-box bus of the masked SubBytes sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface masked_subbytes_ctrl_if #(
    parameter int SHARES = 2
);
    logic                    StartxSI;
    logic [128*SHARES-1:0]   StatexDI;
    logic                    ReadyxSO;
    logic                    BusyxSO;
    logic                    DonexSO;
    logic [128*SHARES-1:0]   StatexDO;
    logic [8*SHARES-1:0]     SboxXxDO;
    logic [8*SHARES-1:0]     SboxQxDI;
    logic                    RndReqxSO;

    modport slave (
        input  StartxSI, StatexDI, SboxQxDI,
        output ReadyxSO, BusyxSO, DonexSO, StatexDO, SboxXxDO, RndReqxSO
    );

    modport master (
        output StartxSI, StatexDI, SboxQxDI,
        input  ReadyxSO, BusyxSO, DonexSO, StatexDO, SboxXxDO, RndReqxSO
    );
endinterface
`default_nettype wire

// File: rtl/masked_subbytes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : masked_subbytes_ctrl
// Brief    : Streams a shared AES state bytewise through a pipelined masked
//            S-box and reassembles the shared SubBytes result.
// Revision : 1.0 - initial release
// ============================================================================
module masked_subbytes_ctrl #(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 5
) (
    input  wire                    ClkxCI,
    input  wire                    RstxBI,
    masked_subbytes_ctrl_if.slave  bus
);

    localparam int                   c_DRAIN_W    = $clog2(SBOX_LATENCY + 1);
    localparam logic [c_DRAIN_W-1:0] c_DRAIN_LAST = c_DRAIN_W'(SBOX_LATENCY - 1);
    localparam logic [3:0]           c_LAST_BYTE  = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic [128*SHARES-1:0]   r_hold;
    logic [128*SHARES-1:0]   r_result;
    logic [3:0]              r_feed_cnt;
    logic [3:0]              r_cap_cnt;
    logic [c_DRAIN_W-1:0]    r_drain_cnt;
    logic [SBOX_LATENCY-1:0] r_vld_sr;
    logic [SBOX_LATENCY:0]   w_vld_sr_nxt;

    logic                    w_ready;
    logic                    w_busy;
    logic                    w_done;
    logic                    w_rnd_req;
    logic                    w_feeding;
    logic                    w_draining;
    logic                    w_start;
    logic                    w_capture;
    logic [8*SHARES-1:0]     w_sbox_x;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge ClkxCI) begin
        if (RstxBI) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_rnd_req   = 1'b0;
        w_feeding   = 1'b0;
        w_draining  = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.StartxSI) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_FEED;
                end
            end
            S_FEED: begin
                w_busy    = 1'b1;
                w_rnd_req = 1'b1;
                w_feeding = 1'b1;
                if (r_feed_cnt == c_LAST_BYTE) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy     = 1'b1;
                w_rnd_req  = 1'b1;
                w_draining = 1'b1;
                // The last drain cycle coincides with the capture of byte 15.
                if (r_drain_cnt == c_DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: holding register, counters, valid pipeline, result capture
    // ------------------------------------------------------------------------
    assign w_vld_sr_nxt = {r_vld_sr, w_feeding};
    assign w_capture    = r_vld_sr[SBOX_LATENCY-1];

    always_ff @(posedge ClkxCI) begin
        if (RstxBI) begin
            r_hold      <= '0;
            r_result    <= '0;
            r_feed_cnt  <= 4'd0;
            r_cap_cnt   <= 4'd0;
            r_drain_cnt <= '0;
            r_vld_sr    <= '0;
        end else begin
            if (w_start) begin
                r_hold <= bus.StatexDI;
            end

            r_feed_cnt  <= w_feeding  ? r_feed_cnt + 4'd1 : 4'd0;
            r_drain_cnt <= w_draining ? r_drain_cnt + c_DRAIN_W'(1) : '0;
            r_vld_sr    <= w_vld_sr_nxt[SBOX_LATENCY-1:0];

            // Each share is written independently; shares are never mixed.
            if (w_capture) begin
                for (int s = 0; s < SHARES; s++) begin
                    r_result[128*s + 8*r_cap_cnt +: 8] <= bus.SboxQxDI[8*s +: 8];
                end
                r_cap_cnt <= r_cap_cnt + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Byte select towards the S-box, per share
    // ------------------------------------------------------------------------
    for (genvar s = 0; s < SHARES; s++) begin : g_feed_sel
        assign w_sbox_x[8*s +: 8] = w_feeding ? r_hold[128*s + 8*r_feed_cnt +: 8] : 8'h00;
    end

    assign bus.ReadyxSO  = w_ready;
    assign bus.BusyxSO   = w_busy;
    assign bus.DonexSO   = w_done;
    assign bus.RndReqxSO = w_rnd_req;
    assign bus.SboxXxDO  = w_sbox_x;
    assign bus.StatexDO  = r_result;

endmodule
`default_nettype wire

// File: tb/tb_masked_subbytes_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_masked_subbytes_ctrl
// Brief    : Randomized bench with a behavioural masked AES S-box model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_subbytes_ctrl;

    localparam int SHARES = 2;
    localparam int LAT    = 5;
    localparam int SW     = 128 * SHARES;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    masked_subbytes_ctrl_if #(.SHARES(SHARES)) bus_if ();

    masked_subbytes_ctrl #(
        .SHARES       (SHARES),
        .SBOX_LATENCY (LAT)
    ) dut (
        .ClkxCI (clk),
        .RstxBI (rst),
        .bus    (bus_if)
    );

    int            n_checks = 0;
    int            n_errors = 0;
    logic [7:0]    sbox_tab [0:255];
    logic [15:0]   pipe     [0:LAT];
    logic [7:0]    mask     = 8'h00;
    logic [15:0]   last_out = 16'h0;
    logic [SW-1:0] prev_res = '0;
    logic [127:0]  plain_seq;
    logic [127:0]  known_res;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_tab[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Masked S-box model: recombines the input, substitutes, re-splits with a
    // mask that refreshes whenever randomness is requested.
    task automatic model_step();
        logic [7:0]  x;
        logic [15:0] o;
        x = bus_if.SboxXxDO[7:0] ^ bus_if.SboxXxDO[15:8];
        if (bus_if.RndReqxSO) mask = 8'($urandom);
        o = {mask, sbox_tab[x] ^ mask};
        for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
        pipe[0]            = o;
        bus_if.SboxQxDI    = pipe[LAT];
        last_out           = o;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    function automatic logic [SW-1:0] rand_state();
        logic [SW-1:0] v;
        for (int i = 0; i < SW / 32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // mode 0: plain run, 1: extra Start pulses while busy, 2: reset in FEED
    task automatic run(input logic [127:0] plain, input bit rand_share, input bit known, input int mode);
        logic [127:0]  s1;
        logic [127:0]  rexp;
        logic [127:0]  rgot;
        logic [SW-1:0] exp_sh;
        logic [15:0]   outs [0:15];
        int            done_at;
        int            n_done;
        int            n_rdy;
        int            n_nbusy;
        int            n_rnd;
        int            limit;
        s1      = rand_share ? 128'(rand_state()) : 128'h0;
        done_at = 0;
        n_done  = 0;
        n_rdy   = 0;
        n_nbusy = 0;
        n_rnd   = 0;
        limit   = (mode == 1) ? 50 : 17 + LAT + 8;
        tick();
        bus_if.StatexDI = {s1, plain ^ s1};
        bus_if.StartxSI = 1'b1;
        tick();
        for (int j = 1; j <= limit; j++) begin
            if (j > 1) tick();
            if (j == 1) bus_if.StatexDI = rand_state();
            if (j <= 16) outs[j-1] = last_out;
            if (j == LAT + 1) check_val("hold_prev", bus_if.StatexDO, prev_res);
            if (j <= 17 + LAT) begin
                if (bus_if.ReadyxSO)  n_rdy++;
                if (!bus_if.BusyxSO)  n_nbusy++;
                if (bus_if.RndReqxSO) n_rnd++;
            end
            if (bus_if.DonexSO) begin
                n_done++;
                if (done_at == 0) done_at = j;
            end
            if (mode == 1 && (j == 3 || j == 18 || j == 22)) begin
                bus_if.StartxSI = 1'b1;
                bus_if.StatexDI = rand_state();
            end else begin
                bus_if.StartxSI = 1'b0;
            end
            if (mode == 2 && j == 7) rst = 1'b1;
            if (mode == 2 && j == 8) break;
            if (mode == 0 && done_at != 0) break;
        end

        if (mode == 2) begin
            rst = 1'b0;
            check_val("rst_ready", 256'(bus_if.ReadyxSO), 256'(1));
            check_val("rst_busy",  256'(bus_if.BusyxSO),  256'(0));
            check_val("rst_state", bus_if.StatexDO, '0);
            check_val("rst_sbox",  256'(bus_if.SboxXxDO), 256'(0));
            for (int j = 0; j < 30; j++) begin
                tick();
                if (bus_if.DonexSO) n_done++;
            end
            check_val("rst_no_done", 256'(n_done), 256'(0));
            prev_res = '0;
            return;
        end

        check_val("done_lat",     256'(done_at), 256'(17 + LAT));
        check_val("done_cnt",     256'(n_done),  256'(1));
        check_val("ready_in_run", 256'(n_rdy),   256'(0));
        check_val("busy_gap",     256'(n_nbusy), 256'(0));
        check_val("rndreq_cyc",   256'(n_rnd),   256'(16 + LAT));
        for (int k = 0; k < 16; k++) begin
            exp_sh[8*k +: 8]       = outs[k][7:0];
            exp_sh[128 + 8*k +: 8] = outs[k][15:8];
            rexp[8*k +: 8]         = sbox_tab[plain[8*k +: 8]];
        end
        rgot = bus_if.StatexDO[127:0] ^ bus_if.StatexDO[255:128];
        check_val("state_shares", bus_if.StatexDO, exp_sh);
        check_val("recombined",   256'(rgot), 256'(rexp));
        if (known) check_val("known_vector", 256'(rgot), 256'(known_res));
        prev_res = exp_sh;
    endtask

    initial begin
        build_sbox();
        for (int i = 0; i <= LAT; i++) pipe[i] = 16'h0;
        for (int k = 0; k < 16; k++) plain_seq[8*k +: 8] = 8'(k);
        known_res        = 128'h76abd7fe2b670130c56f6bf27b777c63;
        bus_if.StartxSI  = 1'b0;
        bus_if.StatexDI  = '0;
        bus_if.SboxQxDI  = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check_val("reset_ready",  256'(bus_if.ReadyxSO),  256'(1));
        check_val("reset_busy",   256'(bus_if.BusyxSO),   256'(0));
        check_val("reset_done",   256'(bus_if.DonexSO),   256'(0));
        check_val("reset_rndreq", 256'(bus_if.RndReqxSO), 256'(0));
        check_val("reset_state",  bus_if.StatexDO, '0);
        check_val("reset_sbox",   256'(bus_if.SboxXxDO), 256'(0));

        run(plain_seq, 1'b0, 1'b1, 0);
        repeat (2) tick();
        run(plain_seq, 1'b1, 1'b1, 0);
        repeat (2) tick();
        run(128'(rand_state()), 1'b1, 1'b0, 1);
        repeat (2) tick();
        run(128'(rand_state()), 1'b1, 1'b0, 2);
        repeat (2) tick();
        run(plain_seq, 1'b1, 1'b1, 0);
        run(128'(rand_state()), 1'b1, 1'b0, 0);
        for (int r = 0; r < 4; r++) begin
            repeat (int'($urandom_range(0, 3))) tick();
            run(128'(rand_state()), 1'b1, 1'b0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
